// File: rtl/freq_meas_pkg.sv
// Shared types and helpers for the frequency measurement controller.
//   - fm_state_e   : controller FSM state encoding
//   - RANGE_*      : range encodings, RANGE_AUTO selects auto-ranging
//   - MULT_R*      : count-to-frequency multipliers per range
//   - gate_len()   : range -> gate length in clk cycles
//   - range_mult() : range -> multiplier
package freq_meas_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSelect  = 3'd1,
        StGate    = 3'd2,
        StCalc    = 3'd3,
        StPublish = 3'd4
    } fm_state_e;

    localparam logic [1:0] RANGE_0    = 2'd0;
    localparam logic [1:0] RANGE_1    = 2'd1;
    localparam logic [1:0] RANGE_2    = 2'd2;
    localparam logic [1:0] RANGE_AUTO = 2'd3;

    // Shorter gates see fewer edges, so the count is scaled back up.
    localparam int unsigned MULT_R0 = 1;
    localparam int unsigned MULT_R1 = 10;
    localparam int unsigned MULT_R2 = 100;

    function automatic logic [31:0] gate_len(input logic [1:0] rng,
                                             input int unsigned g0,
                                             input int unsigned g1,
                                             input int unsigned g2);
        logic [31:0] len;
        case (rng)
            RANGE_0: len = g0;
            RANGE_1: len = g1;
            RANGE_2: len = g2;
            default: len = g2;
        endcase
        return len;
    endfunction

    function automatic logic [31:0] range_mult(input logic [1:0] rng);
        logic [31:0] m;
        case (rng)
            RANGE_0: m = MULT_R0;
            RANGE_1: m = MULT_R1;
            RANGE_2: m = MULT_R2;
            default: m = MULT_R0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/freq_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset
//   sig_i  : asynchronous input signal
//   rise_o : one-cycle pulse per synchronised rising edge
module freq_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Four-channel gated frequency counter with round-robin channel scan and
// optional auto-ranging.
//   clk, rst       : system clock, synchronous active-high reset
//   enable         : keep measuring while high
//   range_sel      : 0/1/2 fixed range, 3 auto-range
//   ch_en          : channel enable mask
//   sig_in         : asynchronous signals under test
//   fre            : published frequency (count x range multiplier, saturated)
//   fre_ch         : channel of fre
//   fre_range      : range used for fre
//   fre_ovf        : edge counter saturated during the gate
//   fre_valid      : one-cycle strobe, high while the new result is presented
//   busy           : controller not idle
module freq_meas_ctrl
    import freq_meas_pkg::*;
#(
    parameter int unsigned GATE_CYC0 = 100_000_000,
    parameter int unsigned GATE_CYC1 = 10_000_000,
    parameter int unsigned GATE_CYC2 = 1_000_000,
    parameter int unsigned CNT_W     = 28,
    parameter int unsigned AUTO_LO   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  range_sel,
    input  logic [3:0]  ch_en,
    input  logic [3:0]  sig_in,
    output logic [31:0] fre,
    output logic [1:0]  fre_ch,
    output logic [1:0]  fre_range,
    output logic        fre_ovf,
    output logic        fre_valid,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Edge detection runs on every channel all the time, so switching the
    // selected channel never manufactures an edge.
    logic [3:0] edge_pulse;

    for (genvar g = 0; g < 4; g++) begin : g_sync
        freq_edge_sync u_sync (
            .clk_i  (clk),
            .rst_i  (rst),
            .sig_i  (sig_in[g]),
            .rise_o (edge_pulse[g])
        );
    end

    fm_state_e        state_q,     state_d;
    logic [1:0]       rr_ptr_q,    rr_ptr_d;
    logic [1:0]       sel_ch_q,    sel_ch_d;
    logic [1:0]       range_q,     range_d;
    logic             auto_q,      auto_d;
    logic [31:0]      timer_q,     timer_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             ovf_q,       ovf_d;
    logic [31:0]      fre_q,       fre_d;
    logic [1:0]       fre_ch_q,    fre_ch_d;
    logic [1:0]       fre_range_q, fre_range_d;
    logic             fre_ovf_q,   fre_ovf_d;
    logic             fre_valid_q, fre_valid_d;

    // Round-robin pick: first enabled channel at or after rr_ptr_q.
    logic [1:0] next_ch;
    logic       ch_found;
    logic [1:0] cand;

    always_comb begin
        next_ch  = rr_ptr_q;
        ch_found = 1'b0;
        cand     = '0;
        for (int i = 0; i < 4; i++) begin
            cand = rr_ptr_q + 2'(i);
            if (!ch_found && ch_en[cand]) begin
                next_ch  = cand;
                ch_found = 1'b1;
            end
        end
    end

    // Scaled result, clamped to 32 bits.
    logic [31:0] cnt_ext;
    logic [63:0] prod_full;
    logic [31:0] product;

    assign cnt_ext   = 32'(cnt_q);
    assign prod_full = {32'b0, cnt_ext} * {32'b0, range_mult(range_q)};
    assign product   = (prod_full[63:32] != '0) ? 32'hFFFF_FFFF : prod_full[31:0];

    logic step_down;
    assign step_down = auto_q && (cnt_ext < AUTO_LO) && (range_q != RANGE_0) && !ovf_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        sel_ch_d    = sel_ch_q;
        range_d     = range_q;
        auto_d      = auto_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        fre_d       = fre_q;
        fre_ch_d    = fre_ch_q;
        fre_range_d = fre_range_q;
        fre_ovf_d   = fre_ovf_q;
        fre_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && (ch_en != '0)) begin
                    state_d = StSelect;
                end
            end

            StSelect: begin
                cnt_d = '0;
                ovf_d = 1'b0;
                if (!enable || !ch_found) begin
                    state_d = StIdle;
                end else begin
                    sel_ch_d = next_ch;
                    auto_d   = (range_sel == RANGE_AUTO);
                    // Auto mode starts on the shortest gate and steps down.
                    range_d  = (range_sel == RANGE_AUTO) ? RANGE_2 : range_sel;
                    timer_d  = gate_len(range_d, GATE_CYC0, GATE_CYC1, GATE_CYC2) - 32'd1;
                    state_d  = StGate;
                end
            end

            StGate: begin
                if (!enable) begin
                    state_d = StIdle;
                end else begin
                    if (edge_pulse[sel_ch_q]) begin
                        if (cnt_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    if (timer_q == '0) begin
                        state_d = StCalc;
                    end else begin
                        timer_d = timer_q - 32'd1;
                    end
                end
            end

            StCalc: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (step_down) begin
                    range_d = range_q - 2'd1;
                    timer_d = gate_len(range_d, GATE_CYC0, GATE_CYC1, GATE_CYC2) - 32'd1;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = StGate;
                end else begin
                    // Results land on this edge so they are visible during PUBLISH.
                    fre_d       = product;
                    fre_ch_d    = sel_ch_q;
                    fre_range_d = range_q;
                    fre_ovf_d   = ovf_q;
                    fre_valid_d = 1'b1;
                    rr_ptr_d    = sel_ch_q + 2'd1;
                    state_d     = StPublish;
                end
            end

            StPublish: begin
                state_d = (enable && (ch_en != '0)) ? StSelect : StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            sel_ch_q    <= '0;
            range_q     <= '0;
            auto_q      <= 1'b0;
            timer_q     <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            fre_q       <= '0;
            fre_ch_q    <= '0;
            fre_range_q <= '0;
            fre_ovf_q   <= 1'b0;
            fre_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_ch_q    <= sel_ch_d;
            range_q     <= range_d;
            auto_q      <= auto_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            fre_q       <= fre_d;
            fre_ch_q    <= fre_ch_d;
            fre_range_q <= fre_range_d;
            fre_ovf_q   <= fre_ovf_d;
            fre_valid_q <= fre_valid_d;
        end
    end

    assign fre       = fre_q;
    assign fre_ch    = fre_ch_q;
    assign fre_range = fre_range_q;
    assign fre_ovf   = fre_ovf_q;
    assign fre_valid = fre_valid_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/freq_meas_ctrl.md
FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- GATE_CYC0, 100_000_000: gate length for range 0 (1 s at 100 MHz).
- GATE_CYC1, 10_000_000: gate length for range 1.
- GATE_CYC2, 1_000_000: gate length for range 2.
- CNT_W, 28: edge counter width.
- AUTO_LO, 1000: auto-range step-down threshold.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1: single system clock.
- rst, in, 1: reset, synchronous, active-high.
- enable, in, 1: run measurements continuously while high.
- range_sel, in, 2: 0/1/2 selects a fixed range; 3 selects auto-range.
- ch_en, in, 4: channel enable mask.
- sig_in, in, 4: asynchronous signals under test.
- fre, out, 32: published frequency.
- fre_ch, out, 2: channel of fre.
- fre_range, out, 2: range used for fre.
- fre_ovf, out, 1: count saturated.
- fre_valid, out, 1: one-cycle publish strobe.
- busy, out, 1: state is not IDLE.

Function
REQ-003 SHALL synchronise each sig_in bit through 2 flops and detect rising edges in parallel on all 4 channels, so a channel switch produces no spurious edge; input frequency < clk/2 is required.
REQ-004 SHALL implement the FSM states IDLE, SELECT, GATE, CALC and PUBLISH.
REQ-005 IDLE->SELECT when enable=1 and ch_en!=0; otherwise stay in IDLE.
REQ-006 SELECT (1 cycle) SHALL perform these actions:
- Pick the next enabled channel round-robin, starting at last published channel+1, wrapping 3->0.
- Sample ch_en in this cycle only.
- Load the range: range_sel if 0..2; if range_sel=3, range 2.
- Clear the counter.
REQ-007 GATE SHALL last exactly GATE_CYCr cycles and count rising-edge pulses of the selected channel occurring in those cycles.
REQ-008 The counter SHALL saturate at 2^CNT_W-1 and set an internal ovf flag, with no wrap.
REQ-009 CALC (1 cycle) SHALL register product = count x M, with M=1/10/100 for range 0/1/2, saturating at 0xFFFFFFFF.
REQ-010 In auto mode, if count < AUTO_LO and range>0 and ovf=0, CALC SHALL go to GATE with range-1 on the same channel, with the counter cleared and nothing published.
- One step-down occurs per gate.
- Range 0 always publishes.
REQ-011 PUBLISH (1 cycle) SHALL update the outputs:
- fre, fre_ch, fre_range and fre_ovf update.
- fre_valid=1 for this cycle only.
- Next state is SELECT if enable=1 and ch_en!=0, else IDLE.
REQ-012 Latency: fre_valid SHALL assert exactly 2 cycles after the last GATE cycle.
REQ-013 When enable falls in SELECT, GATE or CALC, the FSM SHALL go to IDLE on the next edge with no publish; fre* hold their previous values.
REQ-014 In PUBLISH the publish SHALL complete even if enable is low.
REQ-015 When ch_en=0 at SELECT, the FSM SHALL return to IDLE with no publish.
REQ-016 range_sel changes SHALL take effect only at the next SELECT.
REQ-017 fre* outputs SHALL hold between publishes.
REQ-018 busy SHALL equal (state!=IDLE).

Reset
REQ-019 When rst=1 at a clk edge, the following SHALL be zero:
- state=IDLE.
- fre, fre_ch, fre_range, fre_ovf and fre_valid.
- busy, counters and the round-robin pointer (first channel chosen = lowest enabled ≥0).
- Synchroniser and edge-detector flops.
REQ-020 Reset mid-GATE SHALL abort the measurement with no fre_valid.

Structure
REQ-021 Package freq_meas_pkg SHALL hold:
- The FSM state enum.
- Range encodings (including AUTO=3).
- The multiplier table 1/10/100.
- A function mapping range to gate length.
REQ-022 Sub-module freq_edge_sync (2-flop synchroniser + rising-edge pulse) SHALL be instantiated 4 times.
REQ-023 Gate timer and edge counter SHALL be single shared instances inside freq_meas_ctrl.

Verification
All scenarios use GATE_CYC0=1000, GATE_CYC1=100, GATE_CYC2=10, AUTO_LO=5, unless stated.
REQ-024 Fixed range:
- Stimulus: range_sel=0, ch_en=0001, sig_in[0] period 10 clk.
- Response: fre=100, fre_ch=0, fre_range=0, one fre_valid pulse 2 cycles after gate end.
REQ-025 Range scaling:
- Stimulus: as REQ-024 but range_sel=1.
- Response: fre=100, fre_range=1, publish period 103 cycles.
REQ-026 Auto-range:
- Stimulus: range_sel=3, sig_in[0] period 40 clk.
- Response: range 2 gives <5 edges, then range 1 gives <5, then range 0 publishes fre=25, fre_range=0.
- No fre_valid occurs before the range-0 gate.
REQ-027 Round-robin:
- Stimulus: ch_en=1011, all channels active.
- Response: fre_ch sequence 0,1,3,0,1.
- After ch_en changes to 0100 mid-GATE of ch3, the next channel is 2.
REQ-028 Abort/reset:
- Stimulus: enable dropped at GATE cycle 500.
- Response: no fre_valid, busy=0 next cycle, fre unchanged.
- Stimulus: rst at GATE cycle 500.
- Response: all outputs 0.
REQ-029 Overflow:
- Stimulus: CNT_W=6, range_sel=0, period-2 signal (500 edges).
- Response: fre=63, fre_ovf=1.
